// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory port arbiter.
// FSM state encoding, access size codes and load/store opcodes.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GNT_MEM = 2'd1,
    S_GNT_IF  = 2'd2,
    S_DONE    = 2'd3
  } arb_state_t;

  localparam logic [1:0] SZ_BYTE  = 2'b00;
  localparam logic [1:0] SZ_HALF  = 2'b01;
  localparam logic [1:0] SZ_WORD  = 2'b10;
  localparam logic [1:0] SZ_DWORD = 2'b11;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Saturating 8-bit busy-cycle counter for the memory port arbiter.
// expire flags the busy cycle that brings the count up to limit.
module mem_arb_watchdog (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] limit,
  output logic       expire
);

  logic [7:0] count_q;

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      count_q <= 8'd0;
    end else if (en && count_q != 8'hFF) begin
      count_q <= count_q + 8'd1;
    end
  end

  assign expire = en && (count_q >= limit - 8'd1);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between instruction fetch and the MEM stage.
// Define ARB_FAIRNESS_EN to bound MEM grants while a fetch is waiting.
module mem_port_arbiter #(
  parameter int ADDR_W         = 64,
  parameter int DATA_W         = 64,
  parameter int TIMEOUT_CYCLES = 255,
  parameter int MAX_MEM_STREAK = 4
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              IF_REQ,
  input  logic [ADDR_W-1:0] IF_ADDR,
  output logic              IF_ACK,
  output logic [DATA_W-1:0] IF_RDATA,
  input  logic              MEM_REQ,
  input  logic              MEM_WE,
  input  logic [1:0]        MEM_SIZE,
  input  logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_WDATA,
  output logic              MEM_ACK,
  output logic [DATA_W-1:0] MEM_RDATA,
  output logic              ERR,
  output logic              IF_STALL,
  output logic              MEM_STALL,
  output logic              PORT_V,
  output logic              PORT_WE,
  output logic [1:0]        PORT_SIZE,
  output logic [ADDR_W-1:0] PORT_ADDR,
  output logic [DATA_W-1:0] PORT_WDATA,
  input  logic              PORT_BUSY,
  input  logic [DATA_W-1:0] PORT_RDATA
);

  import mem_arb_pkg::*;

  arb_state_t        state_q, state_d;
  logic              own_if_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic grant_mem, grant_if;
  logic done_ok, done_err;
  logic wd_clr, wd_en, wd_expire;
  logic in_gnt, force_if;

  assign in_gnt = (state_q == S_GNT_MEM) || (state_q == S_GNT_IF);

`ifdef ARB_FAIRNESS_EN
  localparam int STREAK_W = $clog2(MAX_MEM_STREAK + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_MEM_STREAK);

  logic [STREAK_W-1:0] streak_q;

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      streak_q <= '0;
    end else if (grant_if) begin
      streak_q <= '0;
    end else if (grant_mem && IF_REQ && streak_q != STREAK_MAX) begin
      streak_q <= streak_q + 1'b1;
    end
  end

  assign force_if = IF_REQ && (streak_q >= STREAK_MAX);
`else
  assign force_if = 1'b0;
`endif

  mem_arb_watchdog u_wd (
    .clk    (CLK),
    .rst_n  (RESET_N),
    .clr    (wd_clr),
    .en     (wd_en),
    .limit  (8'(TIMEOUT_CYCLES)),
    .expire (wd_expire)
  );

  always_comb begin
    state_d   = state_q;
    grant_mem = 1'b0;
    grant_if  = 1'b0;
    done_ok   = 1'b0;
    done_err  = 1'b0;
    wd_clr    = 1'b0;
    wd_en     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wd_clr = 1'b1;
        if (MEM_REQ && !force_if) begin
          grant_mem = 1'b1;
          state_d   = S_GNT_MEM;
        end else if (IF_REQ) begin
          grant_if = 1'b1;
          state_d  = S_GNT_IF;
        end
      end
      S_GNT_MEM, S_GNT_IF: begin
        wd_en = PORT_BUSY;
        if (!PORT_BUSY) begin
          done_ok = 1'b1;
          state_d = S_DONE;
        end else if (wd_expire) begin
          done_err = 1'b1;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q  <= S_IDLE;
      own_if_q <= 1'b0;
      we_q     <= 1'b0;
      size_q   <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (grant_mem) begin
        own_if_q <= 1'b0;
        we_q     <= MEM_WE;
        size_q   <= MEM_SIZE;
        addr_q   <= MEM_ADDR;
        wdata_q  <= MEM_WDATA;
      end else if (grant_if) begin
        own_if_q <= 1'b1;
        we_q     <= OP_LOAD;
        size_q   <= SZ_DWORD;
        addr_q   <= IF_ADDR;
        wdata_q  <= '0;
      end
      if (done_ok) begin
        rdata_q <= (we_q == OP_STORE) ? '0 : PORT_RDATA;
        err_q   <= 1'b0;
      end else if (done_err) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // Completion data is only presented alongside its ACK.
  assign IF_ACK    = (state_q == S_DONE) && own_if_q;
  assign MEM_ACK   = (state_q == S_DONE) && !own_if_q;
  assign IF_RDATA  = IF_ACK ? rdata_q : '0;
  assign MEM_RDATA = MEM_ACK ? rdata_q : '0;
  assign ERR       = (state_q == S_DONE) && err_q;

  assign IF_STALL  = IF_REQ && !IF_ACK;
  assign MEM_STALL = MEM_REQ && !MEM_ACK;

  assign PORT_V     = in_gnt;
  assign PORT_WE    = we_q;
  assign PORT_SIZE  = size_q;
  assign PORT_ADDR  = addr_q;
  assign PORT_WDATA = wdata_q;

endmodule
